fourstate_scan_rx: RTL

- Receiving end of the 4-state literal drive pattern used across our generated designs.
- Accepts one 4-state word per handshake and classifies every bit as 0, 1, x or z, scanning LANES bits per cycle.
- Returns per-word counts plus the lowest x/z position over a valid/ready output, and keeps a saturating count of words that contained any x/z.
- Simulation-side checker block: classification uses case-equality, so it is not synthesis-targeted.

---
 rtl/fourstate_scan_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fourstate_scan_rx.sv
// Four-state word receiver: classifies every bit of an accepted word as 0/1/x/z,
// LANES bits per cycle, and reports per-class counts plus the lowest x/z index.
// Case-equality classification makes this a simulation-side checker block.
module fourstate_scan_rx #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned ERRW  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(W+1)-1:0]   cnt0,
  output logic [$clog2(W+1)-1:0]   cnt1,
  output logic [$clog2(W+1)-1:0]   cntx,
  output logic [$clog2(W+1)-1:0]   cntz,
  output logic                     has_xz,
  output logic [$clog2(W)-1:0]     first_xz_idx,
  output logic [ERRW-1:0]          err_words
);

  localparam int unsigned CW    = $clog2(W + 1);
  localparam int unsigned IW    = $clog2(W);
  localparam int unsigned NSTEP = W / LANES;
  localparam int unsigned PW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [PW-1:0] LastPtr = PW'(NSTEP - 1);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e          state;
  logic [W-1:0]    word;
  logic [PW-1:0]   ptr;
  logic [LANES-1:0] lane;
  logic [CW-1:0]   add0, add1, addx, addz;
  logic            lane_found;
  logic [IW-1:0]   lane_idx;

  // Classify the current lane; the first x/z hit wins so the index is the lowest.
  always_comb begin
    lane       = word[ptr*LANES +: LANES];
    add0       = '0;
    add1       = '0;
    addx       = '0;
    addz       = '0;
    lane_found = 1'b0;
    lane_idx   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane[i] === 1'b0) begin
        add0 = add0 + 1'b1;
      end else if (lane[i] === 1'b1) begin
        add1 = add1 + 1'b1;
      end else begin
        if (lane[i] === 1'bx) addx = addx + 1'b1;
        else                  addz = addz + 1'b1;
        if (!lane_found) begin
          lane_found = 1'b1;
          lane_idx   = IW'(ptr * LANES + i);
        end
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      cnt0         <= '0;
      cnt1         <= '0;
      cntx         <= '0;
      cntz         <= '0;
      has_xz       <= 1'b0;
      first_xz_idx <= '0;
      err_words    <= '0;
      word         <= '0;
      ptr          <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            word         <= in_data;
            cnt0         <= '0;
            cnt1         <= '0;
            cntx         <= '0;
            cntz         <= '0;
            has_xz       <= 1'b0;
            first_xz_idx <= '0;
            ptr          <= '0;
            in_ready     <= 1'b0;
            state        <= StScan;
          end
        end
        StScan: begin
          cnt0 <= cnt0 + add0;
          cnt1 <= cnt1 + add1;
          cntx <= cntx + addx;
          cntz <= cntz + addz;
          if (!has_xz && lane_found) begin
            has_xz       <= 1'b1;
            first_xz_idx <= lane_idx;
          end
          ptr <= ptr + 1'b1;
          if (ptr == LastPtr) begin
            out_valid <= 1'b1;
            state     <= StReport;
          end
        end
        StReport: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
            // Saturate rather than wrap so a long error run never reads as clean.
            if (has_xz && (err_words != {ERRW{1'b1}})) err_words <= err_words + 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
